// File: rtl/f2i_pipe_pkg.sv
// rtl/f2i_pipe_pkg.sv - shared types and helpers for the float-to-integer converter
package f2i_pipe_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rm_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    SUB  = 3'd1,
    NORM = 3'd2,
    INF  = 3'd3,
    NAN  = 3'd4
  } fclass_t;

  function automatic int f2i_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/f2i_round.sv
// rtl/f2i_round.sv - combinational round-increment decision from rounding mode and guard/sticky
module f2i_round
  import f2i_pipe_pkg::*;
(
  input  rm_t  rm,
  input  logic sign,
  input  logic lsb,
  input  logic guard,
  input  logic sticky,
  output logic inc,
  output logic inexact
);

  always_comb begin
    inexact = guard | sticky;
    case (rm)
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & inexact;
      RUP:     inc = ~sign & inexact;
      RMM:     inc = guard;
      default: inc = guard & (sticky | lsb);
    endcase
  end

endmodule

// File: rtl/f2i_pipe.sv
// rtl/f2i_pipe.sv - 3-stage IEEE-754 to integer converter with rounding modes, flags and backpressure
module f2i_pipe
  import f2i_pipe_pkg::*;
#(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10,
  parameter int INT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op,
  input  logic [2:0]              rm,
  input  logic [EXP_W+FRAC_W:0]   i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INT_W-1:0]        o,
  output logic                    nv,
  output logic                    of,
  output logic                    nx
);

  localparam int ES  = EXP_W + 2;
  localparam int F   = FRAC_W + 2;
  localparam int FXW = INT_W + FRAC_W + 3;
  localparam int MW  = INT_W + 2;
  localparam logic signed [ES-1:0] BIAS = ES'(f2i_bias(EXP_W));
  localparam logic [MW-1:0] LIM_SN = MW'(1) << (INT_W - 1);
  localparam logic [MW-1:0] LIM_SP = LIM_SN - MW'(1);
  localparam logic [MW-1:0] LIM_U  = (MW'(1) << INT_W) - MW'(1);

  typedef struct packed {
    logic           sign;
    logic           op;
    rm_t            rm;
    fclass_t        cls;
    logic           ovf;
    logic [INT_W:0] mag;
    logic           guard;
    logic           sticky;
  } s1_t;

  typedef struct packed {
    logic          sign;
    logic          op;
    fclass_t       cls;
    logic          ovf;
    logic [MW-1:0] mag;
    logic          nx;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic v1, v2, v3, adv;

  assign adv       = ce & (~v3 | out_ready);
  assign in_ready  = adv;
  assign out_valid = v3;

  // S1: classify, unbias, and align into INT_W+1 integer bits with F fraction bits
  logic [EXP_W-1:0]        exp_f;
  logic [FRAC_W-1:0]       frac_f;
  logic signed [ES-1:0]    e_s, sh;
  logic signed [31:0]      e_i;
  logic [FXW-1:0]          fx;
  rm_t                     rm_e;

  assign exp_f  = i[EXP_W+FRAC_W-1:FRAC_W];
  assign frac_f = i[FRAC_W-1:0];
  assign rm_e   = (rm > 3'd4) ? RNE : rm_t'(rm);

  always_comb begin
    s1_d      = '0;
    s1_d.sign = i[EXP_W+FRAC_W];
    s1_d.op   = op;
    s1_d.rm   = rm_e;
    if (exp_f == '0)      s1_d.cls = (frac_f == '0) ? ZERO : SUB;
    else if (&exp_f)      s1_d.cls = (frac_f == '0) ? INF : NAN;
    else                  s1_d.cls = NORM;
    e_s = $signed({2'b00, ((exp_f == '0) ? EXP_W'(1) : exp_f)}) - BIAS;
    sh  = e_s + ES'(2);
    e_i = {{(32-ES){e_s[ES-1]}}, e_s};
    fx  = FXW'({exp_f != '0, frac_f}) << $unsigned(sh);
    s1_d.ovf = (e_i >= INT_W + 1);
    if (e_i < -1) begin
      s1_d.mag    = '0;
      s1_d.guard  = 1'b0;
      s1_d.sticky = |i[EXP_W+FRAC_W-1:0];
    end else begin
      s1_d.mag    = fx[FXW-1:F];
      s1_d.guard  = fx[F-1];
      s1_d.sticky = |fx[F-2:0];
    end
  end

  // S2: round; the extra top bit keeps any carry-out of the increment
  logic inc, inexact;

  f2i_round u_round (
    .rm      (s1_q.rm),
    .sign    (s1_q.sign),
    .lsb     (s1_q.mag[0]),
    .guard   (s1_q.guard),
    .sticky  (s1_q.sticky),
    .inc     (inc),
    .inexact (inexact)
  );

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.op   = s1_q.op;
    s2_d.cls  = s1_q.cls;
    s2_d.ovf  = s1_q.ovf;
    s2_d.mag  = {1'b0, s1_q.mag} + MW'(inc);
    s2_d.nx   = inexact;
  end

  // S3: saturate, apply sign, raise flags
  logic             big;
  logic [INT_W-1:0] sat, o_d;
  logic             nv_d, of_d, nx_d;

  always_comb begin
    big  = s2_q.op ? (s2_q.sign ? (s2_q.mag > LIM_SN) : (s2_q.mag > LIM_SP))
                   : (s2_q.sign ? (s2_q.mag != '0)    : (s2_q.mag > LIM_U));
    sat  = s2_q.op ? {s2_q.sign, {(INT_W-1){~s2_q.sign}}} : {INT_W{~s2_q.sign}};
    o_d  = (s2_q.sign & s2_q.op) ? -s2_q.mag[INT_W-1:0] : s2_q.mag[INT_W-1:0];
    nv_d = 1'b0;
    of_d = 1'b0;
    nx_d = s2_q.nx;
    if (s2_q.cls == NAN) begin
      o_d  = s2_q.op ? {1'b0, {(INT_W-1){1'b1}}} : {INT_W{1'b1}};
      nv_d = 1'b1;
      nx_d = 1'b0;
    end else if (s2_q.cls == INF || s2_q.ovf || big) begin
      o_d  = sat;
      nv_d = 1'b1;
      of_d = 1'b1;
      nx_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      o    <= '0;
      nv   <= 1'b0;
      of   <= 1'b0;
      nx   <= 1'b0;
    end else if (adv) begin
      v1   <= in_valid;
      v2   <= v1;
      v3   <= v2;
      s1_q <= s1_d;
      s2_q <= s2_d;
      if (v2) begin
        o  <= o_d;
        nv <= nv_d;
        of <= of_d;
        nx <= nx_d;
      end
    end
  end

endmodule

// File: tb/tb_f2i_pipe.sv
// tb/tb_f2i_pipe.sv - directed FP16 vectors, backpressure/ce/reset sequences, FP64 random vs real model
module tb_f2i_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ce, in_valid, in_ready, op, out_valid, out_ready, nv, of, nx;
  logic [2:0]  rm;
  logic [15:0] i, o;

  logic        ce64, in_valid64, in_ready64, op64, out_valid64, out_ready64, nv64, of64, nx64;
  logic [2:0]  rm64;
  logic [63:0] i64, o64;

  f2i_pipe dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rm(rm), .i(i), .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .nv(nv), .of(of), .nx(nx)
  );

  f2i_pipe #(.EXP_W(11), .FRAC_W(52), .INT_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .ce(ce64), .in_valid(in_valid64), .in_ready(in_ready64),
    .op(op64), .rm(rm64), .i(i64), .out_valid(out_valid64), .out_ready(out_ready64),
    .o(o64), .nv(nv64), .of(of64), .nx(nx64)
  );

  typedef struct {
    logic [15:0] f;
    logic        op;
    logic [2:0]  rm;
    logic [15:0] o;
    logic [2:0]  fl;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] f, input logic sop, input logic [2:0] srm,
                     input logic [15:0] ro, input logic [2:0] fl);
    vec_t v;
    v.f = f; v.op = sop; v.rm = srm; v.o = ro; v.fl = fl;
    vt.push_back(v);
  endtask

  task automatic run_one(input vec_t v, input string name);
    @(negedge clk);
    i = v.f; op = v.op; rm = v.rm; in_valid = 1'b1; out_ready = 1'b1; ce = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_early"}, 80'(out_valid), 80'(0));
    @(negedge clk);
    check(name, {out_valid, o, nv, of, nx}, {1'b1, v.o, v.fl});
  endtask

  task automatic stream(input bit ce_pulses);
    int sent = 0;
    int got = 0;
    logic prev_hold = 1'b0;
    logic [19:0] prev_state = '0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(negedge clk);
      in_valid = (sent < 6);
      if (sent < 6) begin
        i = vt[sent].f; op = vt[sent].op; rm = vt[sent].rm;
      end
      out_ready = !(c >= 4 && c < 9);
      ce = !(ce_pulses && (c == 2 || c == 5 || c == 6 || c == 10));
      #1;
      check("in_ready", 80'(in_ready), 80'(ce & (~out_valid | out_ready)));
      if (prev_hold) check("hold", 80'({out_valid, o, nv, of, nx}), 80'(prev_state));
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready && ce) begin
        check("stream", {o, nv, of, nx}, {vt[got].o, vt[got].fl});
        got++;
      end
      prev_hold  = !ce || (out_valid && !out_ready);
      prev_state = {out_valid, o, nv, of, nx};
    end
    check("stream_count", 80'(got), 80'(6));
    in_valid = 1'b0; out_ready = 1'b1; ce = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_dup", 80'(out_valid), 80'(0));
    end
  endtask

  function automatic logic [63:0] sat64(input logic s, input logic sop);
    if (sop) return s ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    return s ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [66:0] ref64(input logic [63:0] f, input logic sop, input logic [2:0] rmx);
    real two63, two64, a, fl, fr, m;
    logic s, inc, odd, ovf;
    logic [63:0] u, r;
    two63 = 9223372036854775808.0;
    two64 = 2.0 * two63;
    s = f[63];
    if (f[62:52] == 11'h7FF && f[51:0] != 0)
      return {(sop ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF), 3'b100};
    if (f[62:52] == 11'h7FF) return {sat64(s, sop), 3'b110};
    a  = $bitstoreal({1'b0, f[62:0]});
    fl = $floor(a);
    fr = a - fl;
    odd = (fl < 9007199254740992.0) && ((longint'(fl) % 2) != 0);
    case (rmx)
      3'd1:    inc = 1'b0;
      3'd2:    inc = s && (fr > 0.0);
      3'd3:    inc = !s && (fr > 0.0);
      3'd4:    inc = (fr >= 0.5);
      default: inc = (fr > 0.5) || (fr == 0.5 && odd);
    endcase
    m = fl + (inc ? 1.0 : 0.0);
    if (sop) ovf = s ? (m > two63) : (m >= two63);
    else     ovf = s ? (m != 0.0)  : (m >= two64);
    if (ovf) return {sat64(s, sop), 3'b110};
    if (m >= two63) u = 64'(longint'(m - two63)) | 64'h8000_0000_0000_0000;
    else            u = 64'(longint'(m));
    r = (s && sop) ? -u : u;
    return {r, 2'b00, (fr != 0.0)};
  endfunction

  initial begin
    logic [63:0] f;
    logic [66:0] exp64;
    rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0; rm = 3'd0; i = '0;
    ce64 = 1'b1; in_valid64 = 1'b0; out_ready64 = 1'b1; op64 = 1'b0; rm64 = 3'd0; i64 = '0;

    add(16'h3E00, 1, 0, 16'h0002, 3'b001);
    add(16'h4100, 1, 0, 16'h0002, 3'b001);
    add(16'h4200, 1, 0, 16'h0003, 3'b000);
    add(16'hC100, 1, 1, 16'hFFFE, 3'b001);
    add(16'hC100, 1, 2, 16'hFFFD, 3'b001);
    add(16'hC100, 1, 3, 16'hFFFE, 3'b001);
    add(16'hC100, 1, 4, 16'hFFFD, 3'b001);
    add(16'h7BFF, 1, 0, 16'h7FFF, 3'b110);
    add(16'h7BFF, 0, 0, 16'hFFE0, 3'b000);
    add(16'hF800, 1, 0, 16'h8000, 3'b000);
    add(16'h7C00, 0, 0, 16'hFFFF, 3'b110);
    add(16'h7E00, 1, 0, 16'h7FFF, 3'b100);
    add(16'hBC00, 0, 0, 16'h0000, 3'b110);
    add(16'h8001, 0, 0, 16'h0000, 3'b001);
    add(16'h0001, 1, 3, 16'h0001, 3'b001);
    add(16'h8000, 1, 0, 16'h0000, 3'b000);
    add(16'h3E00, 1, 7, 16'h0002, 3'b001);
    add(16'h3800, 1, 0, 16'h0000, 3'b001);
    add(16'h3800, 1, 4, 16'h0001, 3'b001);
    add(16'hFC00, 1, 0, 16'h8000, 3'b110);
    add(16'hF801, 1, 0, 16'h8000, 3'b110);
    add(16'h7800, 0, 0, 16'h8000, 3'b000);
    add(16'h7800, 1, 0, 16'h7FFF, 3'b110);
    add(16'hBC00, 1, 1, 16'hFFFF, 3'b000);
    add(16'h3C00, 0, 3, 16'h0001, 3'b000);
    add(16'hB800, 0, 2, 16'h0000, 3'b110);
    add(16'hB800, 0, 3, 16'h0000, 3'b001);

    repeat (2) @(negedge clk);
    check("reset_state", {out_valid, o, nv, of, nx, out_valid64}, '0);
    rst_n = 1'b1;

    for (int k = 0; k < vt.size(); k++) run_one(vt[k], $sformatf("vec%0d", k));

    stream(1'b0);
    stream(1'b1);

    // reset with three operands in flight and the first one already at the output
    @(negedge clk);
    out_ready = 1'b0; ce = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i = vt[2+k].f; op = vt[2+k].op; rm = vt[2+k].rm; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check("rst_pre", {out_valid, o, nv, of, nx}, {1'b1, vt[2].o, vt[2].fl});
    rst_n = 1'b0;
    #1;
    check("rst_async", {out_valid, o, nv, of, nx}, '0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rst_stale", 80'(out_valid), 80'(0));
    end
    run_one(vt[0], "post_rst");

    for (int k = 0; k < 150; k++) begin
      case (k)
        0: f = 64'h8000_0000_0000_0000;
        1: f = 64'h7FF0_0000_0000_0000;
        2: f = 64'hFFF8_0000_0000_0000;
        3: f = 64'h0000_0000_0000_0001;
        4: f = 64'hC3E0_0000_0000_0000;
        5: f = 64'h43EF_FFFF_FFFF_FFFF;
        default: begin
          f = {$urandom, $urandom};
          f[62:52] = 11'(1019 + $urandom_range(0, 70));
          if (k % 3 == 0) f[39:0] = '0;
        end
      endcase
      @(negedge clk);
      i64 = f; op64 = 1'($urandom_range(0, 1)); rm64 = 3'($urandom_range(0, 7)); in_valid64 = 1'b1;
      exp64 = ref64(f, op64, rm64);
      @(negedge clk);
      in_valid64 = 1'b0;
      repeat (2) @(negedge clk);
      check($sformatf("fp64_%0d", k), {out_valid64, o64, nv64, of64, nx64}, {1'b1, exp64});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
